// File: rtl/fft_pkg.sv
// ---------------------------------------------------------------------------
// fft_pkg
//
// Shared definitions for the fft_8 datapath blocks.
//   FFT_N       log2 of the frame length (fixed at 3)
//   FFT_POINTS  points per frame (8)
//   FFT_W       width of one sample component, two's complement
//   sample_t    one complex sample: re = real part, im = imaginary part
//   bitrev3     3-bit index reversal used for decimation-in-time ordering
// ---------------------------------------------------------------------------
package fft_pkg;

    localparam int FFT_N      = 3;
    localparam int FFT_POINTS = 8;
    localparam int FFT_W      = 8;

    // "real" is a reserved word, hence the short field names
    typedef struct packed {
        logic [FFT_W-1:0] re;
        logic [FFT_W-1:0] im;
    } sample_t;

    function automatic logic [FFT_N-1:0] bitrev3(input logic [FFT_N-1:0] idx);
        return {idx[0], idx[1], idx[2]};
    endfunction

endpackage

// File: rtl/fft_8_in_bank.sv
// ---------------------------------------------------------------------------
// fft_8_in_bank
//
// One 8-slot complex sample register bank with a single write port and a
// flat, always-visible parallel read-out.
//
// Ports:
//   clk       in   system clock, rising edge
//   rst       in   synchronous active-low reset, zeroes every slot
//   we        in   write enable
//   addr      in   slot written when we=1
//   wr_real   in   real part to store
//   wr_image  in   imaginary part to store
//   rd_real   out  slot k real part at bits [k*W +: W]
//   rd_image  out  slot k imaginary part at bits [k*W +: W]
// ---------------------------------------------------------------------------
module fft_8_in_bank
    import fft_pkg::*;
#(
    parameter int W = FFT_W
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    we,
    input  logic [FFT_N-1:0]        addr,
    input  logic [W-1:0]            wr_real,
    input  logic [W-1:0]            wr_image,
    output logic [FFT_POINTS*W-1:0] rd_real,
    output logic [FFT_POINTS*W-1:0] rd_image
);

    logic [W-1:0] mem_real  [FFT_POINTS];
    logic [W-1:0] mem_image [FFT_POINTS];

    // Storage: reset clears every slot so the read-out is defined at all times.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int k = 0; k < FFT_POINTS; k++) begin
                mem_real[k]  <= '0;
                mem_image[k] <= '0;
            end
        end else if (we) begin
            mem_real[addr]  <= wr_real;
            mem_image[addr] <= wr_image;
        end
    end

    // Flatten the slots onto the parallel buses, slot 0 in the low bits.
    always_comb begin
        rd_real  = '0;
        rd_image = '0;
        for (int k = 0; k < FFT_POINTS; k++) begin
            rd_real[k*W +: W]  = mem_real[k];
            rd_image[k*W +: W] = mem_image[k];
        end
    end

endmodule

// File: rtl/fft_8_in_buffer.sv
// ---------------------------------------------------------------------------
// fft_8_in_buffer
//
// Serial-to-parallel ping-pong input buffer for fft_8. Complex samples arrive
// one per cycle on a valid/ready stream and are packed into 8-point frames.
// Two banks alternate: one is filled while the other is presented to fft_8.
//
// Optional build macro:
//   FFT_IN_BIT_REVERSE_EN  when defined, sample i lands in slot bitrev3(i)
//                          so the frame comes out in bit-reversed order;
//                          otherwise sample i lands in slot i.
//
// Ports:
//   clk          in   system clock, rising edge
//   rst          in   synchronous active-low reset
//   s_valid      in   input sample valid
//   s_ready      out  buffer can accept a sample
//   s_real       in   input sample real part
//   s_image      in   input sample imaginary part
//   frame_valid  out  complete frame presented on x_real/x_image
//   frame_ready  in   fft_8 consumes the presented frame
//   x_real       out  slot k real part at bits [k*W +: W]
//   x_image      out  slot k imaginary part at bits [k*W +: W]
//   frames_out   out  frames handed off, wraps at 0xFFFF
// ---------------------------------------------------------------------------
module fft_8_in_buffer
    import fft_pkg::*;
#(
    parameter int N = FFT_N,
    parameter int W = FFT_W
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    s_valid,
    output logic                    s_ready,
    input  logic [W-1:0]            s_real,
    input  logic [W-1:0]            s_image,
    output logic                    frame_valid,
    input  logic                    frame_ready,
    output logic [FFT_POINTS*W-1:0] x_real,
    output logic [FFT_POINTS*W-1:0] x_image,
    output logic [15:0]             frames_out
);

    logic [1:0]              full;
    logic [1:0]              full_next;
    logic                    wr_bank;
    logic                    rd_bank;
    logic [N-1:0]            wr_cnt;
    logic [N-1:0]            wr_slot;
    logic [15:0]             frame_count;

    logic                    accept;
    logic                    fill_done;
    logic                    drain;
    logic [1:0]              bank_we;
    sample_t                 in_sample;

    logic [FFT_POINTS*W-1:0] bank_real  [2];
    logic [FFT_POINTS*W-1:0] bank_image [2];

    // Handshakes. Both are functions of registers only, so neither side of
    // the buffer ever sees a combinational path from the other side.
    assign s_ready     = ~full[wr_bank];
    assign frame_valid = full[rd_bank];
    assign accept      = s_valid & s_ready;
    assign fill_done   = accept & (wr_cnt == '1);
    assign drain       = frame_valid & frame_ready;
    assign frames_out  = frame_count;

    assign in_sample = '{re: s_real, im: s_image};

    // Slot selection for the incoming sample.
`ifdef FFT_IN_BIT_REVERSE_EN
    assign wr_slot = bitrev3(wr_cnt);
`else
    assign wr_slot = wr_cnt;
`endif

    assign bank_we[0] = accept & ~wr_bank;
    assign bank_we[1] = accept &  wr_bank;

    // Full flags: a fill completes on one bank and a drain empties the other.
    // They can never target the same bank (writes need full=0, reads need
    // full=1), so applying both in sequence is safe.
    always_comb begin
        full_next = full;
        if (fill_done) begin
            full_next[wr_bank] = 1'b1;
        end
        if (drain) begin
            full_next[rd_bank] = 1'b0;
        end
    end

    // Pointer, flag and counter registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            full        <= '0;
            wr_bank     <= 1'b0;
            rd_bank     <= 1'b0;
            wr_cnt      <= '0;
            frame_count <= '0;
        end else begin
            full <= full_next;
            if (accept) begin
                wr_cnt <= wr_cnt + 1'b1;
            end
            if (fill_done) begin
                wr_bank <= ~wr_bank;
            end
            if (drain) begin
                rd_bank     <= ~rd_bank;
                frame_count <= frame_count + 16'd1;
            end
        end
    end

    // The two ping-pong banks.
    for (genvar b = 0; b < 2; b++) begin : g_bank
        fft_8_in_bank #(
            .W (W)
        ) u_bank (
            .clk      (clk),
            .rst      (rst),
            .we       (bank_we[b]),
            .addr     (wr_slot),
            .wr_real  (in_sample.re),
            .wr_image (in_sample.im),
            .rd_real  (bank_real[b]),
            .rd_image (bank_image[b])
        );
    end

    // Output mux always follows the read bank; it only changes on a drain,
    // so the presented frame is stable until fft_8 takes it.
    assign x_real  = rd_bank ? bank_real[1]  : bank_real[0];
    assign x_image = rd_bank ? bank_image[1] : bank_image[0];

endmodule

// File: tb/tb_fft_8_in_buffer.sv
// ---------------------------------------------------------------------------
// tb_fft_8_in_buffer
//
// Self-checking bench for fft_8_in_buffer. The stimulus process drives the
// sample stream and the consumer handshake; a monitor keeps a behavioural
// model (a partial-frame list plus a queue of completed frames) and checks
// the handshakes, frame contents and frame counter every cycle.
// Honours FFT_IN_BIT_REVERSE_EN the same way as the design.
// ---------------------------------------------------------------------------
module tb_fft_8_in_buffer;

    logic        clk = 1'b0;
    logic        rst;
    logic        s_valid;
    logic        s_ready;
    logic [7:0]  s_real;
    logic [7:0]  s_image;
    logic        frame_valid;
    logic        frame_ready;
    logic [63:0] x_real;
    logic [63:0] x_image;
    logic [15:0] frames_out;

    int checks = 0;
    int passes = 0;

    // Behavioural model state
    logic [7:0]  part_re [8];
    logic [7:0]  part_im [8];
    int          part_n  = 0;
    logic [63:0] exp_re_q [$];
    logic [63:0] exp_im_q [$];
    int          drained = 0;

    bit random_phase = 1'b0;

    fft_8_in_buffer dut (
        .clk         (clk),
        .rst         (rst),
        .s_valid     (s_valid),
        .s_ready     (s_ready),
        .s_real      (s_real),
        .s_image     (s_image),
        .frame_valid (frame_valid),
        .frame_ready (frame_ready),
        .x_real      (x_real),
        .x_image     (x_image),
        .frames_out  (frames_out)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        checks++;
        if (actual === expected) begin
            passes++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t",
                     name, actual, expected, $time);
        end
    endtask

    // Frame slot that sample index i occupies.
    function automatic int slotOf(input int i);
`ifdef FFT_IN_BIT_REVERSE_EN
        return ((i & 1) << 2) | (i & 2) | ((i >> 2) & 1);
`else
        return i;
`endif
    endfunction

    // Monitor and scoreboard: check against the model, then advance it by
    // the handshakes that will take effect at the coming rising edge.
    always @(negedge clk) begin
        if (rst !== 1'b1) begin
            part_n  = 0;
            drained = 0;
            exp_re_q.delete();
            exp_im_q.delete();
        end else begin
            int  pending;
            bit  exp_sready;
            bit  exp_fvalid;
            pending    = exp_re_q.size();
            exp_sready = (pending < 2);
            exp_fvalid = (pending > 0);
            checkOutput("s_ready", 64'(s_ready), 64'(exp_sready));
            checkOutput("frame_valid", 64'(frame_valid), 64'(exp_fvalid));
            checkOutput("frames_out", 64'(frames_out), 64'(drained & 16'hFFFF));
            if (exp_fvalid && frame_ready) begin
                checkOutput("x_real", x_real, exp_re_q[0]);
                checkOutput("x_image", x_image, exp_im_q[0]);
                void'(exp_re_q.pop_front());
                void'(exp_im_q.pop_front());
                drained++;
            end
            if (s_valid && exp_sready) begin
                part_re[part_n] = s_real;
                part_im[part_n] = s_image;
                part_n++;
                if (part_n == 8) begin
                    logic [63:0] fr;
                    logic [63:0] fi;
                    fr = '0;
                    fi = '0;
                    for (int j = 0; j < 8; j++) begin
                        fr[slotOf(j)*8 +: 8] = part_re[j];
                        fi[slotOf(j)*8 +: 8] = part_im[j];
                    end
                    exp_re_q.push_back(fr);
                    exp_im_q.push_back(fi);
                    part_n = 0;
                end
            end
        end
    end

    // Offer one sample and return just after the edge that accepts it.
    task automatic applyStimulus(input logic [7:0] re, input logic [7:0] im);
        int waited = 0;
        s_valid = 1'b1;
        s_real  = re;
        s_image = im;
        @(negedge clk);
        while (!s_ready && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        if (!s_ready) begin
            checkOutput("accept_timeout", 64'(waited), 64'd0);
        end
        @(posedge clk);
        #1;
        s_valid = 1'b0;
    endtask

    task automatic applyReset();
        rst         = 1'b0;
        s_valid     = 1'b0;
        s_real      = '0;
        s_image     = '0;
        frame_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    task automatic pulseReady();
        frame_ready = 1'b1;
        @(posedge clk);
        #1;
        frame_ready = 1'b0;
    endtask

    // Let the consumer take everything that is complete.
    task automatic drainAll();
        int waited = 0;
        frame_ready = 1'b1;
        @(negedge clk);
        while (exp_re_q.size() != 0 && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        checkOutput("drain_empty", 64'(exp_re_q.size()), 64'd0);
        @(posedge clk);
        #1;
        frame_ready = 1'b0;
    endtask

    localparam logic [7:0] SINGLE [8] = '{8'h39, 8'h57, 8'h57, 8'h39,
                                          8'h57, 8'h57, 8'h39, 8'h57};

    initial begin
        // Reset values
        applyReset();
        @(negedge clk);
        checkOutput("reset_s_ready", 64'(s_ready), 64'd1);
        checkOutput("reset_frame_valid", 64'(frame_valid), 64'd0);
        checkOutput("reset_x_real", x_real, 64'd0);
        checkOutput("reset_x_image", x_image, 64'd0);
        checkOutput("reset_frames_out", 64'(frames_out), 64'd0);
        @(posedge clk);
        #1;

        // Single frame, held by the consumer
        for (int i = 0; i < 8; i++) begin
            applyStimulus(SINGLE[i], 8'h00);
        end
        @(negedge clk);
        checkOutput("single_valid", 64'(frame_valid), 64'd1);
        checkOutput("single_x_real", x_real, 64'h5739_5757_3957_5739);
        checkOutput("single_x_image", x_image, 64'd0);
        @(posedge clk);
        #1;
        pulseReady();

        // Backpressure: two full banks, a held 17th sample, then one drain
        for (int i = 0; i < 16; i++) begin
            applyStimulus(8'($urandom), 8'($urandom));
        end
        @(negedge clk);
        checkOutput("bp_s_ready", 64'(s_ready), 64'd0);
        @(posedge clk);
        #1;
        fork
            applyStimulus(8'hA5, 8'h5A);
            begin
                repeat (4) @(posedge clk);
                #1;
                pulseReady();
            end
        join
        for (int i = 0; i < 7; i++) begin
            applyStimulus(8'($urandom), 8'($urandom));
        end
        drainAll();

        // Streaming at full rate
        applyReset();
        frame_ready = 1'b1;
        for (int i = 0; i < 64; i++) begin
            applyStimulus(8'(i), 8'(255 - i));
        end
        drainAll();

        // Reset in the middle of a frame
        for (int i = 0; i < 5; i++) begin
            applyStimulus(8'hEE, 8'hEE);
        end
        applyReset();
        for (int i = 0; i < 8; i++) begin
            applyStimulus(8'(8'h10 + i), 8'(8'h80 + i));
        end
        drainAll();

        // Fill of bank 1 completes on the same edge bank 0 is drained
        applyReset();
        for (int i = 0; i < 15; i++) begin
            applyStimulus(8'($urandom), 8'($urandom));
        end
        frame_ready = 1'b1;
        applyStimulus(8'h7F, 8'h80);
        frame_ready = 1'b0;
        @(negedge clk);
        checkOutput("simul_frame_valid", 64'(frame_valid), 64'd1);
        checkOutput("simul_s_ready", 64'(s_ready), 64'd1);
        @(posedge clk);
        #1;
        drainAll();

        // Random traffic with a randomly stalling consumer
        random_phase = 1'b1;
        fork
            begin
                for (int i = 0; i < 400; i++) begin
                    if ($urandom_range(0, 3) == 0) begin
                        @(posedge clk);
                        #1;
                    end
                    applyStimulus(8'($urandom), 8'($urandom));
                end
                random_phase = 1'b0;
            end
            begin
                while (random_phase) begin
                    @(posedge clk);
                    #1;
                    frame_ready = 1'($urandom_range(0, 1));
                end
            end
        join
        drainAll();
        checkOutput("final_partial", 64'(part_n), 64'd0);

        repeat (2) @(posedge clk);
        $display("[TB] %0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
